// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-captures two IRQ lines plus a periodic timer, arbitrates
// (source 1 first) and issues one-cycle dispatch pulses, blocking nesting until iret.
module intr_ctrl #(
    parameter int TW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          irq1_in,
    input  logic          irq2_in,
    input  logic          iret,
    input  logic          cpu_block,
    input  logic          mask_we,
    input  logic [1:0]    mask_d,
    input  logic          tmr_we,
    input  logic [TW-1:0] tmr_d,
    output logic          s_intr1,
    output logic          s_intr2,
    output logic          in_service,
    output logic [1:0]    pending
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        SERVICE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          sel_q, sel_d;       // 0: source 1, 1: source 2
    logic [1:0]    pend_q, pend_d;
    logic [1:0]    mask_q;
    logic [1:0]    prev_q;
    logic [TW-1:0] period_q;
    logic [TW-1:0] count_q, count_d;
    logic          tick;
    logic [1:0]    rise;
    logic [1:0]    set_req;
    logic [1:0]    clr_req;
    logic [1:0]    eligible;

    always_comb begin
        tick    = 1'b0;
        count_d = count_q;
        if (tmr_we) begin
            count_d = '0;
        end else if (period_q != '0) begin
            if (count_q == period_q - TW'(1)) begin
                count_d = '0;
                tick    = 1'b1;
            end else begin
                count_d = count_q + TW'(1);
            end
        end
    end

    always_comb begin
        rise     = {irq2_in & ~prev_q[1], irq1_in & ~prev_q[0]};
        set_req  = rise | {tick, 1'b0};
        eligible = pend_q & mask_q;
        state_d  = state_q;
        sel_d    = sel_q;
        clr_req  = 2'b00;
        case (state_q)
            IDLE: begin
                if (!cpu_block && (eligible != 2'b00)) begin
                    state_d = DISPATCH;
                    sel_d   = ~eligible[0];
                    clr_req = eligible[0] ? 2'b01 : 2'b10;
                end
            end
            DISPATCH: state_d = SERVICE;
            SERVICE: begin
                if (iret) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new event in the same cycle as the dispatch clear must survive.
        pend_d = (pend_q & ~clr_req) | set_req;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            pend_q   <= 2'b00;
            mask_q   <= 2'b00;
            period_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            count_q <= count_d;
            if (mask_we) begin
                mask_q <= mask_d;
            end
            if (tmr_we) begin
                period_q <= tmr_d;
            end
        end
    end

    // Edge history tracks the lines even in reset, so a line held high across
    // reset is not mistaken for a fresh request once reset releases.
    always_ff @(posedge clk) begin
        prev_q <= {irq2_in, irq1_in};
    end

    assign s_intr1    = (state_q == DISPATCH) && !sel_q;
    assign s_intr2    = (state_q == DISPATCH) &&  sel_q;
    assign in_service = (state_q != IDLE);
    assign pending    = pend_q;

endmodule
